// File: rtl/mvm_axis_injector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mvm_axis_injector                                             |
// | Purpose  : Host-side command injector for mvm_top. Accepts commands,     |
// |            formats each into a single-flit AXIS packet (TUSER = row      |
// |            one-hot, op, RF addr), buffers them in a small FIFO and       |
// |            drives them out through one output register.                  |
// | Ports    : CLK/RST         clock, async active-high reset                |
// |            CMD_*           command valid/ready handshake and fields      |
// |            AXIS_M_*        AXI-Stream master towards mvm_top             |
// |            LEVEL           FIFO occupancy (output register excluded)     |
// |            PKT_CNT         wrapping count of flits handed off            |
// |            ERR             one-cycle pulse per accepted illegal op (01)  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mvm_axis_injector #(
  parameter int DATAW      = 512,
  parameter int IDW        = 8,
  parameter int DESTW      = 12,
  parameter int USERW      = 75,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            CMD_VALID,
  output logic                            CMD_READY,
  input  logic [1:0]                      CMD_OP,
  input  logic [8:0]                      CMD_RF_ADDR,
  input  logic [5:0]                      CMD_ROW,
  input  logic [DESTW-1:0]                CMD_DEST,
  input  logic [IDW-1:0]                  CMD_ID,
  input  logic [DATAW-1:0]                CMD_DATA,
  output logic                            AXIS_M_TVALID,
  input  logic                            AXIS_M_TREADY,
  output logic [DATAW-1:0]                AXIS_M_TDATA,
  output logic [IDW-1:0]                  AXIS_M_TID,
  output logic [DESTW-1:0]                AXIS_M_TDEST,
  output logic [USERW-1:0]                AXIS_M_TUSER,
  output logic                            AXIS_M_TLAST,
  output logic [$clog2(FIFO_DEPTH):0]     LEVEL,
  output logic [15:0]                     PKT_CNT,
  output logic                            ERR
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int ROWW = USERW - 11;
  localparam int EW   = USERW + DESTW + IDW + DATAW;
  localparam logic [LW-1:0] C_DEPTH = LW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

  ostate_t          r_state;
  ostate_t          w_state_nxt;
  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [EW-1:0]    r_out;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [15:0]      r_pkt_cnt;
  logic             r_err;

  logic [ROWW-1:0]  w_row;
  logic [EW-1:0]    w_entry;
  logic             w_accept;
  logic             w_legal;
  logic             w_hs;
  logic             w_out_free;
  logic             w_fifo_empty;
  logic             w_bypass;
  logic             w_pop;
  logic             w_push;

  // Formatting happens at enqueue so the FIFO stores ready-to-send flits.
  assign w_row   = (CMD_OP == 2'b11) ? (ROWW'(1) << CMD_ROW) : '0;
  assign w_entry = {w_row, CMD_OP, CMD_RF_ADDR, CMD_DEST, CMD_ID, CMD_DATA};

  // READY depends on registered occupancy only, so no TREADY->READY path.
  assign CMD_READY    = (r_level < C_DEPTH);
  assign w_accept     = CMD_VALID & CMD_READY;
  assign w_legal      = (CMD_OP != 2'b01);
  assign w_hs         = (r_state == ST_FULL) & AXIS_M_TREADY;
  assign w_out_free   = (r_state == ST_EMPTY) | w_hs;
  assign w_fifo_empty = (r_level == '0);
  // Bypass only when nothing is queued, which keeps strict ordering.
  assign w_bypass     = w_accept & w_legal & w_fifo_empty & w_out_free;
  assign w_pop        = ~w_fifo_empty & w_out_free;
  assign w_push       = w_accept & w_legal & ~w_bypass;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_pop | w_bypass) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_hs & ~(w_pop | w_bypass)) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Storage array needs no reset: pointers and LEVEL gate every read.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_pkt_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_legal;
      if (w_pop)         r_out <= r_mem[r_rptr];
      else if (w_bypass) r_out <= w_entry;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push & ~w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop & ~w_push) r_level <= r_level - LW'(1);
      if (w_hs) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign AXIS_M_TVALID = (r_state == ST_FULL);
  assign AXIS_M_TLAST  = (r_state == ST_FULL);
  assign AXIS_M_TDATA  = r_out[DATAW-1:0];
  assign AXIS_M_TID    = r_out[DATAW +: IDW];
  assign AXIS_M_TDEST  = r_out[DATAW+IDW +: DESTW];
  assign AXIS_M_TUSER  = r_out[DATAW+IDW+DESTW +: USERW];
  assign LEVEL         = r_level;
  assign PKT_CNT       = r_pkt_cnt;
  assign ERR           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mvm_axis_injector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mvm_axis_injector                                          |
// | Purpose  : Directed self-checking bench for mvm_axis_injector.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mvm_axis_injector;

  localparam int DATAW = 512;
  localparam int IDW   = 8;
  localparam int DESTW = 12;
  localparam int USERW = 75;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic [1:0]       CMD_OP = 2'b00;
  logic [8:0]       CMD_RF_ADDR = '0;
  logic [5:0]       CMD_ROW = '0;
  logic [DESTW-1:0] CMD_DEST = '0;
  logic [IDW-1:0]   CMD_ID = '0;
  logic [DATAW-1:0] CMD_DATA = '0;
  logic             AXIS_M_TVALID;
  logic             AXIS_M_TREADY = 1'b0;
  logic [DATAW-1:0] AXIS_M_TDATA;
  logic [IDW-1:0]   AXIS_M_TID;
  logic [DESTW-1:0] AXIS_M_TDEST;
  logic [USERW-1:0] AXIS_M_TUSER;
  logic             AXIS_M_TLAST;
  logic [2:0]       LEVEL;
  logic [15:0]      PKT_CNT;
  logic             ERR;

  int n_vec = 0;
  int n_err = 0;

  mvm_axis_injector dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_RF_ADDR(CMD_RF_ADDR), .CMD_ROW(CMD_ROW), .CMD_DEST(CMD_DEST),
    .CMD_ID(CMD_ID), .CMD_DATA(CMD_DATA),
    .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
    .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TID(AXIS_M_TID),
    .AXIS_M_TDEST(AXIS_M_TDEST), .AXIS_M_TUSER(AXIS_M_TUSER),
    .AXIS_M_TLAST(AXIS_M_TLAST), .LEVEL(LEVEL), .PKT_CNT(PKT_CNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [8:0] addr, input logic [5:0] row,
                         input logic [DESTW-1:0] dest, input logic [IDW-1:0] id,
                         input logic [DATAW-1:0] data);
    CMD_VALID   = 1'b1;
    CMD_OP      = op;
    CMD_RF_ADDR = addr;
    CMD_ROW     = row;
    CMD_DEST    = dest;
    CMD_ID      = id;
    CMD_DATA    = data;
  endtask

  initial begin
    logic [DATAW-1:0] a5;
    int sent;
    int rcvd;
    int cyc;
    logic acc;

    a5 = {64{8'hA5}};

    // Reset state
    tick();
    check_eq("rst_tvalid", AXIS_M_TVALID, 1'b0);
    check_eq("rst_tlast",  AXIS_M_TLAST, 1'b0);
    check_eq("rst_tdata",  AXIS_M_TDATA, '0);
    check_eq("rst_tuser",  AXIS_M_TUSER, '0);
    check_eq("rst_level",  LEVEL, 3'd0);
    check_eq("rst_pktcnt", PKT_CNT, 16'd0);
    check_eq("rst_err",    ERR, 1'b0);
    RST = 1'b0;
    tick();
    check_eq("rst_ready",  CMD_READY, 1'b1);

    // RF write: op 11, addr 1, row 5 -> TUSER = (1<<16)|(3<<9)|1 = 0x10601
    AXIS_M_TREADY = 1'b1;
    set_cmd(2'b11, 9'h001, 6'd5, 12'h001, 8'h11, 512'h1234);
    tick();
    CMD_VALID = 1'b0;
    check_eq("rfw_tvalid", AXIS_M_TVALID, 1'b1);
    check_eq("rfw_tlast",  AXIS_M_TLAST, 1'b1);
    check_eq("rfw_tuser",  AXIS_M_TUSER, 75'h10601);
    check_eq("rfw_tdest",  AXIS_M_TDEST, 12'h001);
    check_eq("rfw_tid",    AXIS_M_TID, 8'h11);
    check_eq("rfw_tdata",  AXIS_M_TDATA, 512'h1234);
    tick();
    check_eq("rfw_pktcnt", PKT_CNT, 16'd1);
    check_eq("rfw_idle",   AXIS_M_TVALID, 1'b0);

    // Vector then instruction, back to back
    set_cmd(2'b10, 9'h002, 6'd7, 12'h001, 8'h21, a5);
    tick();
    check_eq("vec_tuser",  AXIS_M_TUSER, 75'h402);
    check_eq("vec_tdata",  AXIS_M_TDATA, a5);
    set_cmd(2'b00, 9'h003, 6'd9, 12'h001, 8'h22, 512'h80C0200E);
    tick();
    CMD_VALID = 1'b0;
    check_eq("ins_tvalid", AXIS_M_TVALID, 1'b1);
    check_eq("ins_tuser",  AXIS_M_TUSER, 75'h003);
    check_eq("ins_tdata",  AXIS_M_TDATA, 512'h80C0200E);
    check_eq("ins_tid",    AXIS_M_TID, 8'h22);
    tick();
    check_eq("vi_pktcnt",  PKT_CNT, 16'd3);

    // Backpressure: one in output register, four in FIFO, sixth refused
    AXIS_M_TREADY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_cmd(2'b10, 9'(i), 6'd0, 12'h002, 8'(i), 512'(32'h100 + i));
      check_eq("bp_ready", CMD_READY, (i < 5) ? 1'b1 : 1'b0);
      tick();
    end
    CMD_VALID = 1'b0;
    check_eq("bp_level", LEVEL, 3'd4);
    check_eq("bp_ready_full", CMD_READY, 1'b0);
    tick();
    tick();
    check_eq("bp_stall_valid", AXIS_M_TVALID, 1'b1);
    check_eq("bp_stall_data",  AXIS_M_TDATA, 512'h100);
    AXIS_M_TREADY = 1'b1;
    check_eq("bp_ready_hs", CMD_READY, 1'b0);
    for (int i = 1; i < 5; i++) begin
      tick();
      check_eq("bp_drain_data",  AXIS_M_TDATA, 512'(32'h100 + i));
      check_eq("bp_drain_level", LEVEL, 3'(4 - i));
      check_eq("bp_drain_ready", CMD_READY, 1'b1);
    end
    tick();
    check_eq("bp_empty", AXIS_M_TVALID, 1'b0);
    check_eq("bp_pktcnt", PKT_CNT, 16'd8);

    // Illegal op 01
    set_cmd(2'b01, 9'h005, 6'd0, 12'h003, 8'h33, 512'hDEAD);
    tick();
    CMD_VALID = 1'b0;
    check_eq("ill_err",    ERR, 1'b1);
    check_eq("ill_tvalid", AXIS_M_TVALID, 1'b0);
    check_eq("ill_level",  LEVEL, 3'd0);
    tick();
    check_eq("ill_err_clr", ERR, 1'b0);
    check_eq("ill_pktcnt",  PKT_CNT, 16'd8);
    check_eq("ill_tvalid2", AXIS_M_TVALID, 1'b0);

    // 20 commands with TREADY toggling every cycle
    sent = 0; rcvd = 0; cyc = 0;
    while ((rcvd < 20) && (cyc < 400)) begin
      AXIS_M_TREADY = cyc[0];
      if (sent < 20) set_cmd(2'b10, 9'h0, 6'd0, 12'h004, 8'(sent), 512'(32'h2000 + sent));
      else CMD_VALID = 1'b0;
      acc = CMD_VALID & CMD_READY;
      if (AXIS_M_TVALID & AXIS_M_TREADY) begin
        check_eq("wrap_order", AXIS_M_TDATA, 512'(32'h2000 + rcvd));
        rcvd++;
      end
      tick();
      if (acc) sent++;
      cyc++;
    end
    CMD_VALID = 1'b0;
    check_eq("wrap_rcvd", 32'(rcvd), 32'd20);
    check_eq("wrap_pktcnt", PKT_CNT, 16'd28);
    check_eq("wrap_level", LEVEL, 3'd0);

    // Drive PKT_CNT up to 0xFFFF, then one more send wraps it to 0
    AXIS_M_TREADY = 1'b1;
    set_cmd(2'b00, 9'h0, 6'd0, 12'h005, 8'h0, 512'h0);
    for (int i = 0; i < 65535 - 28; i++) tick();
    CMD_VALID = 1'b0;
    tick();
    check_eq("cnt_max", PKT_CNT, 16'hFFFF);
    set_cmd(2'b00, 9'h0, 6'd0, 12'h005, 8'h0, 512'h0);
    tick();
    CMD_VALID = 1'b0;
    tick();
    check_eq("cnt_wrap", PKT_CNT, 16'h0000);
    set_cmd(2'b00, 9'h0, 6'd0, 12'h005, 8'h0, 512'h0);
    tick();
    CMD_VALID = 1'b0;
    tick();
    check_eq("cnt_post_wrap", PKT_CNT, 16'h0001);

    // Reset mid-operation: LEVEL=3 with a stalled flit
    AXIS_M_TREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(2'b10, 9'h0, 6'd0, 12'h006, 8'(i), 512'(32'h3000 + i));
      tick();
    end
    CMD_VALID = 1'b0;
    check_eq("mid_level",  LEVEL, 3'd3);
    check_eq("mid_tvalid", AXIS_M_TVALID, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("mid_rst_tvalid", AXIS_M_TVALID, 1'b0);
    check_eq("mid_rst_level",  LEVEL, 3'd0);
    check_eq("mid_rst_pktcnt", PKT_CNT, 16'd0);
    AXIS_M_TREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mid_no_stale", AXIS_M_TVALID, 1'b0);
    end
    check_eq("mid_pktcnt_end", PKT_CNT, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
